mux_4_1_rr_arbiter: RTL and testbench
=====================================

# mux_4_1_rr_arbiter

Round-robin arbiter that shares one 4:1 data path between four requesters and one downstream consumer. It picks a requester, drives the mux select, and presents the selected word with a valid/ready handshake. Arbitration is fair across requesters. It sits directly in front of the `mux_4_1` data path and owns its `sel` input.

## Interface
- `DATA_WIDTH`, 8: width of each requester word and of `out_data`.
- `CNT_WIDTH`, 16: width of each grant-statistics counter. Used only with `MUX_ARB_STATS_EN`.

Ports:
- `clk`  in  1  single clock; rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  4  request per requester; bit i belongs to requester i.
- `in0`..`in3`  in  DATA_WIDTH each  requester data. Must be held stable while that requester's `req` is high.
- `grant`  out  4  one-hot current grant; all zero when idle.
- `sel`  out  2  registered mux select; index of the current or last grant.
- `out_valid`  out  1  `out_data` holds a word for the consumer.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_WIDTH  output of the `in0`..`in3` mux, selected by `sel`.
- `busy`  out  1  high in state SEND.
- `cnt_sel`  in  2  statistics counter select. Present only with `MUX_ARB_STATS_EN`.
- `cnt_out`  out  CNT_WIDTH  selected statistics counter. Present only with `MUX_ARB_STATS_EN`.

## Operation
- Two-state FSM: IDLE and SEND. Reset state is IDLE.
- Round-robin pointer `ptr` (2 bits): the highest-priority requester for the next arbitration.
- **IDLE:** if `req` != 0, pick the first set bit scanning `ptr`, `ptr+1`, … (mod 4). Register `sel` to that index and set `grant` one-hot to the same index, then go to SEND. If `req` == 0, stay in IDLE.
- **SEND:** `out_valid` = 1, `grant` held, `out_data` = `in[sel]`.
- **Handshake:** a transfer happens in a cycle with `out_valid` && `out_ready`. On the next edge:
  - state goes to IDLE,
  - `grant` goes to 0,
  - `ptr` = `sel`+1 (mod 4).
- **Abort:** if `req[sel]` drops in SEND without a handshake in the same cycle, the FSM goes to IDLE. `grant` clears and `ptr` = `sel`+1. This is not a transfer.
- If the handshake and the drop of `req[sel]` occur in the same cycle, it counts as a transfer.
- Requests arriving in SEND wait. There is no preemption.
- `sel` holds its last value while idle.
- `out_ready` is ignored while `out_valid` = 0.

## Timing
- Reset values:
  - `grant` = 0, `sel` = 0, `ptr` = 0
  - `out_valid` = 0, `busy` = 0
  - all counters = 0
- `out_data` is combinational from `sel` and `in0`..`in3`. It is meaningful only while `out_valid` = 1.
- Latency: `req` rises in cycle N (FSM in IDLE) → `grant`/`out_valid` high from cycle N+1.
- Throughput: at most one transfer per 2 cycles (SEND → IDLE → SEND).
- Under consumer backpressure, `out_valid`, `grant` and `sel` stay stable until accepted.
- Reset asserted mid-SEND: all outputs take reset values immediately (asynchronous). The word is dropped.
- With all four requesters held high, grants rotate 0,1,2,3,0,…

## Configuration
- Macro: `MUX_ARB_STATS_EN`.
- **Defined:**
  - four CNT_WIDTH counters; counter i increments on each completed transfer with `sel` = i;
  - counters saturate at all-ones and are not incremented by aborts;
  - `cnt_out` = counter[`cnt_sel`], combinational;
  - `cnt_sel` and `cnt_out` ports exist.
- **Undefined:** no counters, no `cnt_sel`/`cnt_out` ports. Arbitration behaviour is identical.

## Structure
- Shared package `mux_arb_pkg` holds:
  - FSM state encoding (IDLE = 0, SEND = 1),
  - requester count (4),
  - the select width (2).
- Sub-module: one `mux_4_1` instance with `DATA_WIDTH` passed through, `sel` driven by the registered `sel`, output to `out_data`.
- Round-robin pick is a local function or combinational block. It is not a separate module.

## Test plan
- **Reset:** `rst_n` = 0 with `req` = 4'b1111 → `grant` = 0, `out_valid` = 0, `sel` = 0. After release → first grant is requester 0.
- **Rotation:** `req` = 4'b1111, `out_ready` = 1, `in0`..`in3` = 8'hA0..8'hA3 → `out_data` sequence A0, A1, A2, A3, A0, each valid for 1 cycle every 2 cycles.
- **Skip:** `ptr` = 1, `req` = 4'b0001 → grant requester 0. Next, `req` = 4'b1001 → grant requester 3.
- **Backpressure:** `req` = 4'b0100, `out_ready` = 0 for 5 cycles → `out_valid`, `grant` = 4'b0100 and `out_data` held. `out_ready` = 1 → one transfer, then `grant` = 0.
- **Abort:** in SEND for requester 2, drop `req[2]` with `out_ready` = 0 → IDLE next cycle, no transfer, `ptr` = 3.
- **Stats** (with `MUX_ARB_STATS_EN`, `CNT_WIDTH` = 2): 5 transfers from requester 1 → `cnt_sel` = 1 gives `cnt_out` = 3 (saturated); other counters = 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin arbitrated 4:1 data path:
// FSM state encoding, requester count and mux select width.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux_4_1.sv
// Plain combinational 4:1 word multiplexer; the arbiter owns its select.
module mux_4_1
  import mux_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  input  logic [SEL_W-1:0]      sel,
  output logic [DATA_WIDTH-1:0] out
);

  // Word selection
  always_comb begin
    out = in0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter in front of a mux_4_1 with a valid/ready output.
// Optional per-requester grant statistics are enabled by MUX_ARB_STATS_EN.
module mux_4_1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  output logic [N_REQ-1:0]      grant,
  output logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
`ifdef MUX_ARB_STATS_EN
  ,
  input  logic [SEL_W-1:0]      cnt_sel,
  output logic [CNT_WIDTH-1:0]  cnt_out
`endif
);

  arb_state_e       state_r, state_s;
  logic [SEL_W-1:0] ptr_r, ptr_s;
  logic [SEL_W-1:0] sel_r, sel_s;
  logic [N_REQ-1:0] grant_r, grant_s;
  logic [SEL_W-1:0] pick_s;
  logic             xfer_s;

  // First requesting index scanning upward from ptr, wrapping modulo 4.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = p + SEL_W'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Next-state, grant and pointer update
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    sel_s   = sel_r;
    grant_s = grant_r;
    xfer_s  = 1'b0;
    pick_s  = rr_pick(req, ptr_r);
    case (state_r)
      IDLE: begin
        if (req != {N_REQ{1'b0}}) begin
          state_s = SEND;
          sel_s   = pick_s;
          grant_s = N_REQ'(1) << pick_s;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        // A handshake wins over a simultaneous request drop.
        if (out_ready || !req[sel_r]) begin
          state_s = IDLE;
          grant_s = {N_REQ{1'b0}};
          ptr_s   = sel_r + 2'd1;
          xfer_s  = out_ready;
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = {N_REQ{1'b0}};
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      sel_r   <= 2'd0;
      grant_r <= {N_REQ{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      sel_r   <= sel_s;
      grant_r <= grant_s;
    end
  end

  assign grant     = grant_r;
  assign sel       = sel_r;
  assign out_valid = (state_r == SEND);
  assign busy      = (state_r == SEND);

  mux_4_1 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .sel(sel_r),
    .out(out_data)
  );

`ifdef MUX_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_r [N_REQ];

  // Saturating completed-transfer counters, one per requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else if (xfer_s && (cnt_r[sel_r] != {CNT_WIDTH{1'b1}})) begin
      cnt_r[sel_r] <= cnt_r[sel_r] + CNT_WIDTH'(1);
    end else begin
      cnt_r[sel_r] <= cnt_r[sel_r];
    end
  end

  assign cnt_out = cnt_r[cnt_sel];
`else
  if (CNT_WIDTH > 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Self-checking bench for mux_4_1_rr_arbiter: directed scenarios plus
// randomized traffic against a behavioural round-robin model.
module tb_mux_4_1_rr_arbiter;

  localparam int DW = 8;
`ifdef MUX_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [3:0]    req = 4'b0000;
  logic [DW-1:0] din [4];
  logic [3:0]    grant;
  logic [1:0]    sel;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
`ifdef MUX_ARB_STATS_EN
  logic [1:0]    cnt_sel = 2'd0;
  logic [CW-1:0] cnt_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model
  bit m_active;
  int m_owner;
  int m_ptr;
  int m_sel;

  always #5 clk = ~clk;

  mux_4_1_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .grant(grant), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
`ifdef MUX_ARB_STATS_EN
    , .cnt_sel(cnt_sel), .cnt_out(cnt_out)
`endif
  );

  function automatic int model_pick(input logic [3:0] r, input int p);
    int first = -1;
    for (int k = 0; k < 4; k++) begin
      if (first < 0 && r[(p + k) % 4]) first = (p + k) % 4;
    end
    return first;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_active = 1'b0; m_owner = 0; m_ptr = 0; m_sel = 0;
    end else if (!m_active) begin
      if (req != 4'b0000) begin
        m_owner  = model_pick(req, m_ptr);
        m_sel    = m_owner;
        m_active = 1'b1;
      end
    end else if (out_ready || !req[m_owner]) begin
      m_active = 1'b0;
      m_ptr    = (m_owner + 1) % 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b0;
    #2;
    n_checks++;
    if (grant !== 4'b0000 || out_valid !== 1'b0 || sel !== 2'd0 || busy !== 1'b0)
      $display("FAIL reset_async: grant=%b valid=%b sel=%0d busy=%b, want 0000/0/0/0", grant, out_valid, sel, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || out_valid !== 1'b0)
      $display("FAIL reset_held: grant=%b valid=%b, want 0000/0", grant, out_valid);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (grant !== 4'b0001 || sel !== 2'd0 || out_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL reset_first_grant: grant=%b sel=%0d valid=%b busy=%b, want 0001/0/1/1", grant, sel, out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_rotation();
    logic [DW-1:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) din[i] = 8'hA0 + DW'(i);
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (out_valid !== ((k % 2) == 0))
        $display("FAIL rotation_valid: cycle %0d valid=%b, want %0d", k, out_valid, (k % 2) == 0);
      else n_pass++;
      if ((k % 2) == 0) begin
        exp_d = 8'hA0 + DW'((k / 2) % 4);
        n_checks++;
        if (out_data !== exp_d)
          $display("FAIL rotation_data: cycle %0d data=%h, want %h", k, out_data, exp_d);
        else n_pass++;
      end
    end
  endtask

  task automatic test_skip();
    do_reset();
    req = 4'b0001; out_ready = 1'b1;
    tick(); tick();      // grant 0, then transfer: pointer now 1
    tick();
    n_checks++;
    if (grant !== 4'b0001 || sel !== 2'd0)
      $display("FAIL skip_wrap: grant=%b sel=%0d, want 0001/0", grant, sel);
    else n_pass++;
    tick();              // transfer: pointer 1 again
    req = 4'b1001;
    tick();
    n_checks++;
    if (grant !== 4'b1000 || sel !== 2'd3)
      $display("FAIL skip_to_3: grant=%b sel=%0d, want 1000/3", grant, sel);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    din[2] = 8'h5C; req = 4'b0100; out_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || grant !== 4'b0100 || sel !== 2'd2 || out_data !== 8'h5C)
        $display("FAIL backpressure_hold: cycle %0d valid=%b grant=%b sel=%0d data=%h, want 1/0100/2/5c",
                 k, out_valid, grant, sel, out_data);
      else n_pass++;
    end
    out_ready = 1'b1;
    req = 4'b0000;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || out_valid !== 1'b0 || sel !== 2'd2)
      $display("FAIL backpressure_release: grant=%b valid=%b sel=%0d, want 0000/0/2", grant, out_valid, sel);
    else n_pass++;
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0100; out_ready = 1'b0;
    tick();
    req = 4'b0000;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_idle: grant=%b valid=%b busy=%b, want 0000/0/0", grant, out_valid, busy);
    else n_pass++;
    req = 4'b1111;
    tick();
    n_checks++;
    if (grant !== 4'b1000 || sel !== 2'd3)
      $display("FAIL abort_ptr: grant=%b sel=%0d, want 1000/3", grant, sel);
    else n_pass++;
`ifdef MUX_ARB_STATS_EN
    cnt_sel = 2'd2;
    #1;
    n_checks++;
    if (cnt_out !== 2'd0)
      $display("FAIL abort_no_count: cnt2=%0d, want 0", cnt_out);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010; out_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || out_valid !== 1'b0 || sel !== 2'd0 || busy !== 1'b0)
      $display("FAIL async_reset_midsend: grant=%b valid=%b sel=%0d busy=%b, want 0000/0/0/0",
               grant, out_valid, sel, busy);
    else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0]    nreq;
    logic [3:0]    exp_g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) begin
          din[i]  = DW'($urandom);
          nreq[i] = ($urandom_range(0, 2) == 0);
        end else begin
          nreq[i] = ($urandom_range(0, 7) != 0);
        end
      end
      req = nreq;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      exp_g = m_active ? (4'b0001 << m_owner) : 4'b0000;
      n_checks++;
      if (grant !== exp_g || sel !== 2'(m_sel) || out_valid !== m_active || busy !== m_active)
        $display("FAIL random_ctrl: cycle %0d grant=%b sel=%0d valid=%b busy=%b, want %b/%0d/%0d/%0d",
                 c, grant, sel, out_valid, busy, exp_g, m_sel, m_active, m_active);
      else n_pass++;
      if (m_active) begin
        n_checks++;
        if (out_data !== din[m_sel])
          $display("FAIL random_data: cycle %0d data=%h, want %h", c, out_data, din[m_sel]);
        else n_pass++;
      end
    end
  endtask

`ifdef MUX_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req = 4'b0010; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    req = 4'b0000;
    tick();
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      #1;
      n_checks++;
      if (cnt_out !== ((i == 1) ? 2'd3 : 2'd0))
        $display("FAIL stats_cnt%0d: got %0d, want %0d", i, cnt_out, (i == 1) ? 3 : 0);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    m_active = 1'b0; m_owner = 0; m_ptr = 0; m_sel = 0;
    #1;
    test_reset();
    test_rotation();
    test_skip();
    test_backpressure();
    test_abort();
    test_async_reset();
`ifdef MUX_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
